// File: rtl/sm83_tgen.sv
// SM83 T-state sequencer: t1..t4 phase strobes, power-on reset hold, HALT/STOP, M-cycle counter.
// Optional memory wait-state stretch on T2 is enabled by defining SM83_TGEN_WAIT_EN.
module sm83_tgen #(
    parameter int unsigned RESET_MCYCLES = 2,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 ce,
    input  logic                 halt,
    input  logic                 stop,
    input  logic                 irq_pend,
    input  logic                 wake_stop,
    input  logic                 wait_req,
    output logic                 t1,
    output logic                 t2,
    output logic                 t3,
    output logic                 t4,
    output logic                 reset,
    output logic                 halted,
    output logic                 stopped,
    output logic [CNT_WIDTH-1:0] mcycle_cnt
);

    localparam int unsigned HOLD_W = 4;

    typedef enum logic [1:0] {ST_RST, ST_RUN, ST_HALT, ST_STOP} state_t;
    typedef enum logic [1:0] {PH_T1, PH_T2, PH_T3, PH_T4} phase_t;

    state_t              state;
    phase_t              phase;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_next;
    logic                stretch;
    phase_t              phase_nxt;
    logic [3:0]          strobe_nxt;

    // T2 is held while memory requests wait states (RUN/HALT only)
`ifdef SM83_TGEN_WAIT_EN
    assign stretch = wait_req && t2 && ((state == ST_RUN) || (state == ST_HALT));
`else
    logic unused_wait_req;
    assign unused_wait_req = wait_req;
    assign stretch         = 1'b0;
`endif

    // Next phase and its one-hot strobe pattern (bit 0 = t1)
    always_comb begin
        hold_next  = hold_cnt + HOLD_W'(1);
        phase_nxt  = phase;
        if (!stretch) begin
            phase_nxt = phase_t'(2'(phase + 2'd1));
        end
        strobe_nxt = 4'b0001 << phase_nxt;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= ST_RST;
            phase      <= PH_T4;
            hold_cnt   <= '0;
            t1         <= 1'b0;
            t2         <= 1'b0;
            t3         <= 1'b0;
            t4         <= 1'b0;
            reset      <= 1'b1;
            halted     <= 1'b0;
            stopped    <= 1'b0;
            mcycle_cnt <= '0;
        end else if (ce) begin
            unique case (state)
                ST_RST: begin
                    phase <= phase_nxt;
                    {t4, t3, t2, t1} <= strobe_nxt;
                    if (t4) begin
                        hold_cnt <= hold_next;
                        if (hold_next == HOLD_W'(RESET_MCYCLES)) begin
                            state <= ST_RUN;
                            reset <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    phase <= phase_nxt;
                    {t4, t3, t2, t1} <= strobe_nxt;
                    if (t4) begin
                        mcycle_cnt <= mcycle_cnt + CNT_WIDTH'(1);
                        if (stop) begin
                            // Park on T4 so the wake edge produces T1
                            state            <= ST_STOP;
                            stopped          <= 1'b1;
                            phase            <= PH_T4;
                            {t4, t3, t2, t1} <= 4'b0000;
                        end else if (halt && !irq_pend) begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    phase <= phase_nxt;
                    {t4, t3, t2, t1} <= strobe_nxt;
                    if (t4) begin
                        mcycle_cnt <= mcycle_cnt + CNT_WIDTH'(1);
                        if (irq_pend) begin
                            state  <= ST_RUN;
                            halted <= 1'b0;
                        end
                    end
                end
                ST_STOP: begin
                    if (wake_stop) begin
                        state   <= ST_RUN;
                        stopped <= 1'b0;
                        phase   <= PH_T1;
                        t1      <= 1'b1;
                    end
                end
                default: state <= ST_RST;
            endcase
        end
    end

endmodule

// File: doc/sm83_tgen.md
# sm83_tgen

T-state sequencer for the SM83 core. Generates the one-hot `t1`..`t4` phase strobes that drive the bus I/O stage and the control unit, and holds the core in synchronous reset for a fixed number of M-cycles after power-on. Also implements the HALT and STOP low-power states, an optional memory wait-state stretch, and a free-running M-cycle counter. Sits directly upstream of the bus I/O stage: its `t1`..`t4` and `reset` outputs are that stage's phase and reset inputs.

## Interface

Parameters:

- `RESET_MCYCLES`, default 2: number of complete M-cycles `reset` stays high after `n_reset` deasserts. Legal range is 1..15.
- `CNT_WIDTH`, default 16: width of `mcycle_cnt`.

Ports:

- `clk` in 1: the single clock.
- `n_reset` in 1: asynchronous, active-low reset.
- `ce` in 1: clock enable. When low, no register changes.
- `halt` in 1: HALT request from the control unit. Sampled on `t4`.
- `stop` in 1: STOP request from the control unit. Sampled on `t4`.
- `irq_pend` in 1: interrupt pending. Wakes the block from HALT.
- `wake_stop` in 1: external wake (joypad). Exits STOP.
- `wait_req` in 1: memory wait request. Only effective with `SM83_TGEN_WAIT_EN`.
- `t1`, `t2`, `t3`, `t4` out 1 each: one-hot phase strobes.
- `reset` out 1: synchronous core reset, active high.
- `halted` out 1: high while in the HALT state.
- `stopped` out 1: high while in the STOP state.
- `mcycle_cnt` out `CNT_WIDTH`: M-cycle counter.

## Operation

- State machine states: RST, RUN, HALT, STOP.
- Asynchronous reset (`n_reset` low) forces:
  - state RST, phase register = T4 (so the first enabled edge yields T1);
  - `t1`..`t4` = 0;
  - `reset` = 1, `halted` = 0, `stopped` = 0, `mcycle_cnt` = 0;
  - reset-hold counter = 0.
- Phase advance: each `ce` edge outside STOP moves T1→T2→T3→T4→T1. Strobes are registered, with exactly one high outside reset and STOP.
- RST:
  - Phases run normally.
  - Each `t4` increments the hold counter.
  - On the `t4` where the hold counter reaches `RESET_MCYCLES`: go to RUN; `reset` drops on the following T1.
  - `halt`, `stop`, `wait_req` and `irq_pend` are ignored.
- RUN, on a `t4` cycle:
  - `stop` set → STOP. `stop` wins over `halt` when both are set.
  - Else `halt` set and `irq_pend` clear → HALT.
  - Else `halt` set and `irq_pend` set → stay in RUN (HALT is not entered).
- HALT:
  - Strobes keep cycling and `mcycle_cnt` keeps counting.
  - `halted` = 1 from the T1 after entry.
  - `irq_pend` sampled high on `t4` → RUN; `halted` = 0 from the next T1.
- STOP:
  - All strobes are 0, `stopped` = 1, `mcycle_cnt` is frozen, phase register holds T4.
  - `wake_stop` high on any `ce` cycle → RUN; `t1` = 1 and `stopped` = 0 on the next edge.
- `mcycle_cnt`:
  - Increments by 1 on every `t4` in RUN and HALT. Does not count in RST or STOP.
  - Modulo 2^`CNT_WIDTH`: wraps all-ones → 0 silently.

## Timing

- All outputs are registered, with zero combinational paths from inputs to outputs.
- State changes and the corresponding output changes take effect on the edge that ends the sampling cycle.
- M-cycle length is 4 `ce` cycles, plus wait cycles when enabled.
- `ce` low: every register holds, including the hold counter and `mcycle_cnt`. `ce` low during STOP delays the wake.
- Reset release: the first `ce` edge after `n_reset` rises gives `t1`. With `RESET_MCYCLES` = 2, `reset` is high for 8 strobe cycles and is low alongside the 9th strobe (a `t1`).
- Asserting `n_reset` mid-M-cycle zeroes the strobes immediately, with no completion of the current M-cycle.
- Simultaneous `wake_stop` and `n_reset` low: reset wins.

## Configuration

- `SM83_TGEN_WAIT_EN` defined:
  - In RUN and HALT, `wait_req` high during a `t2` cycle keeps the phase at T2 for another cycle.
  - Repeats each cycle with no limit.
  - `t3` follows the first `t2` cycle with `wait_req` low.
  - `wait_req` is ignored in RST and STOP and in phases other than T2.
- Undefined: `wait_req` is unused and the phase always advances; behaviour is otherwise identical.

## Test plan

- Release `n_reset`, `ce`=1, `RESET_MCYCLES`=2 → strobes T1..T4 twice with `reset`=1 for 8 cycles; cycle 9 shows `t1`=1, `reset`=0; `mcycle_cnt`=0.
- In RUN, `ce` pattern 1,0,0,1 starting at T2 → T2 held for 3 cycles, then T3. `mcycle_cnt` is unchanged until `t4`.
- `halt`=1 on `t4` with `irq_pend`=0 → `halted`=1 from the next T1 and strobes continue. `irq_pend`=1 on a later `t4` → `halted`=0 at the next T1. Repeating with `irq_pend`=1 at the HALT request → `halted` stays 0.
- `halt`=`stop`=1 on `t4` → `stopped`=1, strobes 0, `mcycle_cnt` frozen for 20 cycles. Pulse `wake_stop` → `t1`=1 on the next edge, `stopped`=0.
- With `SM83_TGEN_WAIT_EN`: `wait_req`=1 for 3 cycles from T2 → `t2` high for 4 cycles, then T3. Without the macro → T3 on the cycle after the first T2.
- Preload `mcycle_cnt` to 0xFFFF via a run of 65535 M-cycles; the next `t4` → 0x0000. Assert `n_reset` during T3 → all strobes 0 and `reset`=1 immediately.
